// File: rtl/ram_loader.sv
// ram_loader: program loader placed in front of a small synchronous RAM.
// Owns the RAM address/write/read/data pins and muxes them between the CPU
// datapath and a byte-stream loader. On request it holds the CPU, writes N
// streamed bytes into consecutive RAM addresses starting at a base address,
// pulses done for one cycle, then hands the RAM back to the CPU.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   load_req/base/len       load request, first address, byte count (clamped to depth)
//   in_valid/in_data        byte stream in; in_ready high while loading
//   cpu_addr/ri/ro/data     CPU-side RAM controls, passed through while idle
//   mem_address/ri/ro/data_i  RAM-side controls
//   cpu_hold                CPU stall while the loader owns the RAM (registered)
//   busy                    loader not idle (registered)
//   done                    one-cycle completion pulse (registered)
module ram_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_ri,
    input  logic              cpu_ro,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              ri,
    output logic              ro,
    output logic [DATA_W-1:0] data_i,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept_c;

    // A byte is taken whenever the loader is in LOAD and the stream offers one.
    assign accept_c = (state_q == ST_LOAD) && in_valid;

    // Next-state, pointer/counter update and registered-output decode.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;

        case (state_q)
            ST_IDLE: begin
                if (load_req) begin
                    if (load_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d       = load_base;
                        remaining_d = (load_len > DEPTH_CNT) ? DEPTH_CNT : load_len;
                        state_d     = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept_c) begin
                    ptr_d       = ptr_q + ADDR_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Decoded from the next state so the flops track the state register exactly.
        cpu_hold_d = (state_d != ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            cpu_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // RAM pin mux: CPU passthrough when idle, loader-owned otherwise.
    always_comb begin
        mem_address = cpu_addr;
        ri          = cpu_ri;
        ro          = cpu_ro;
        data_i      = cpu_data;
        in_ready    = 1'b0;

        case (state_q)
            ST_LOAD: begin
                mem_address = ptr_q;
                ri          = accept_c;
                ro          = 1'b0;
                data_i      = in_data;
                in_ready    = 1'b1;
            end
            ST_DONE: begin
                mem_address = ptr_q;
                ri          = 1'b0;
                ro          = 1'b0;
                data_i      = in_data;
            end
            default: begin
            end
        endcase
    end

    assign cpu_hold = cpu_hold_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
